// File: rtl/mips_multicycle_ctrl_if.sv
// rtl/mips_multicycle_ctrl_if.sv - instruction fields in, datapath/memory controls out
interface mips_multicycle_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       iord;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcen;
    logic [2:0] alucontrol;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  op, funct, zero,
        output memread, memwrite, irwrite, regwrite, regdst, memtoreg, iord,
               alusrca, alusrcb, pcsrc, pcen, alucontrol, illegal, state
    );

    modport slave (
        output op, funct, zero,
        input  memread, memwrite, irwrite, regwrite, regdst, memtoreg, iord,
               alusrca, alusrcb, pcsrc, pcen, alucontrol, illegal, state
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS control FSM
module mips_multicycle_ctrl #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic                   clk,
    input  logic                   reset,
    mips_multicycle_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,  S_DECODE  = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB   = 4'd4,  S_MEMWR   = 4'd5,  S_RTYPEEX = 4'd6, S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,  S_ADDIEX  = 4'd9,  S_ADDIWB = 4'd10, S_JEX    = 4'd11
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t     cur, nxt;
    logic       memread_c, memwrite_c, irwrite_c, regwrite_c, regdst_c, memtoreg_c;
    logic       iord_c, alusrca_c, pcwrite_c, branch_c, illegal_c;
    logic [1:0] alusrcb_c, pcsrc_c;
    logic [2:0] alucontrol_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cur <= S_FETCH;
        else       cur <= nxt;
    end

    always_comb begin
        nxt          = S_FETCH;
        memread_c    = 1'b0;
        memwrite_c   = 1'b0;
        irwrite_c    = 1'b0;
        regwrite_c   = 1'b0;
        regdst_c     = 1'b0;
        memtoreg_c   = 1'b0;
        iord_c       = 1'b0;
        alusrca_c    = 1'b0;
        alusrcb_c    = 2'b00;
        pcsrc_c      = 2'b00;
        pcwrite_c    = 1'b0;
        branch_c     = 1'b0;
        alucontrol_c = ALU_ADD;
        illegal_c    = 1'b0;
        case (cur)
            S_FETCH: begin
                memread_c = 1'b1;
                irwrite_c = 1'b1;
                alusrcb_c = 2'b01;
                pcwrite_c = 1'b1;
                nxt       = S_DECODE;
            end
            S_DECODE: begin
                alusrcb_c = 2'b11;
                case (bus.op)
                    OP_LW, OP_SW: nxt = S_MEMADR;
                    OP_RTYPE:     nxt = S_RTYPEEX;
                    OP_BEQ:       nxt = S_BEQEX;
                    OP_ADDI:      nxt = S_ADDIEX;
                    OP_J:         nxt = S_JEX;
                    default:      illegal_c = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alusrca_c = 1'b1;
                alusrcb_c = 2'b10;
                nxt       = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                memread_c = 1'b1;
                iord_c    = 1'b1;
                nxt       = S_MEMWB;
            end
            S_MEMWB: begin
                regwrite_c = 1'b1;
                memtoreg_c = 1'b1;
            end
            S_MEMWR: begin
                memwrite_c = 1'b1;
                iord_c     = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca_c = 1'b1;
                nxt       = S_RTYPEWB;
                case (bus.funct)
                    6'b100000: alucontrol_c = ALU_ADD;
                    6'b100010: alucontrol_c = ALU_SUB;
                    6'b100100: alucontrol_c = ALU_AND;
                    6'b100101: alucontrol_c = ALU_OR;
                    6'b101010: alucontrol_c = ALU_SLT;
                    default: begin
                        // Unsupported funct: flag it and skip the writeback
                        illegal_c = 1'b1;
                        nxt       = S_FETCH;
                    end
                endcase
            end
            S_RTYPEWB: begin
                regwrite_c = 1'b1;
                regdst_c   = 1'b1;
            end
            S_BEQEX: begin
                alusrca_c    = 1'b1;
                alucontrol_c = ALU_SUB;
                branch_c     = 1'b1;
                pcsrc_c      = 2'b01;
            end
            S_ADDIEX: begin
                alusrca_c = 1'b1;
                alusrcb_c = 2'b10;
                nxt       = S_ADDIWB;
            end
            S_ADDIWB: regwrite_c = 1'b1;
            S_JEX: begin
                pcwrite_c = 1'b1;
                pcsrc_c   = 2'b10;
            end
            default: nxt = S_FETCH;
        endcase
    end

    // Reset forces every output low even though the state register already holds FETCH
    assign bus.memread    = ~reset & memread_c;
    assign bus.memwrite   = ~reset & memwrite_c;
    assign bus.irwrite    = ~reset & irwrite_c;
    assign bus.regwrite   = ~reset & regwrite_c;
    assign bus.regdst     = ~reset & regdst_c;
    assign bus.memtoreg   = ~reset & memtoreg_c;
    assign bus.iord       = ~reset & iord_c;
    assign bus.alusrca    = ~reset & alusrca_c;
    assign bus.alusrcb    = reset ? 2'b00 : alusrcb_c;
    assign bus.pcsrc      = reset ? 2'b00 : pcsrc_c;
    assign bus.pcen       = ~reset & (pcwrite_c | (branch_c & bus.zero));
    assign bus.alucontrol = reset ? 3'b000 : alucontrol_c;
    assign bus.illegal    = ~reset & illegal_c;
    assign bus.state      = reset ? 4'd0 : cur;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - directed bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    mips_multicycle_ctrl_if bus ();

    mips_multicycle_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // {memread,memwrite,irwrite,regwrite,regdst,memtoreg,iord,alusrca,alusrcb,pcsrc,pcen,alucontrol,illegal}
    localparam logic [16:0] V_ZERO    = 17'b0;
    localparam logic [16:0] V_FETCH   = {8'b1010_0000, 2'b01, 2'b00, 1'b1, 3'b010, 1'b0};
    localparam logic [16:0] V_DECODE  = {8'b0000_0000, 2'b11, 2'b00, 1'b0, 3'b010, 1'b0};
    localparam logic [16:0] V_DEC_ILL = {8'b0000_0000, 2'b11, 2'b00, 1'b0, 3'b010, 1'b1};
    localparam logic [16:0] V_MEMADR  = {8'b0000_0001, 2'b10, 2'b00, 1'b0, 3'b010, 1'b0};
    localparam logic [16:0] V_MEMRD   = {8'b1000_0010, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0};
    localparam logic [16:0] V_MEMWB   = {8'b0001_0100, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0};
    localparam logic [16:0] V_MEMWR   = {8'b0100_0010, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0};
    localparam logic [16:0] V_RTYPEWB = {8'b0001_1000, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0};
    localparam logic [16:0] V_BEQ_T   = {8'b0000_0001, 2'b00, 2'b01, 1'b1, 3'b110, 1'b0};
    localparam logic [16:0] V_BEQ_N   = {8'b0000_0001, 2'b00, 2'b01, 1'b0, 3'b110, 1'b0};
    localparam logic [16:0] V_ADDIEX  = {8'b0000_0001, 2'b10, 2'b00, 1'b0, 3'b010, 1'b0};
    localparam logic [16:0] V_ADDIWB  = {8'b0001_0000, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0};
    localparam logic [16:0] V_JEX     = {8'b0000_0000, 2'b00, 2'b10, 1'b1, 3'b010, 1'b0};
    localparam logic [16:0] V_R_ILL   = {8'b0000_0001, 2'b00, 2'b00, 1'b0, 3'b010, 1'b1};

    function automatic logic [16:0] v_rex(input logic [2:0] alu);
        return {8'b0000_0001, 2'b00, 2'b00, 1'b0, alu, 1'b0};
    endfunction

    logic [16:0] obs_vec;
    assign obs_vec = {bus.memread, bus.memwrite, bus.irwrite, bus.regwrite, bus.regdst,
                      bus.memtoreg, bus.iord, bus.alusrca, bus.alusrcb, bus.pcsrc,
                      bus.pcen, bus.alucontrol, bus.illegal};

    task automatic chk(input string tag, input logic [3:0] exp_state, input logic [16:0] exp_vec);
        checks++;
        assert (bus.state === exp_state) else begin
            errors++;
            $error("FAIL %s state: observed %0d expected %0d", tag, bus.state, exp_state);
        end
        checks++;
        assert (obs_vec === exp_vec) else begin
            errors++;
            $error("FAIL %s outputs: observed %b expected %b", tag, obs_vec, exp_vec);
        end
        checks++;
        assert (!(bus.memread && bus.memwrite)) else begin
            errors++;
            $error("FAIL %s strobes: observed memread=1 memwrite=1 expected not both", tag);
        end
    endtask

    // Check the current cycle, then advance to the middle of the next one
    task automatic step(input string tag, input logic [3:0] exp_state, input logic [16:0] exp_vec);
        chk(tag, exp_state, exp_vec);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        bus.op    = 6'b100011;
        bus.funct = 6'b000000;
        bus.zero  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("reset_c1", 4'd0, V_ZERO);
        @(posedge clk);
        @(negedge clk);
        chk("reset_c2", 4'd0, V_ZERO);
        reset = 1'b0;
        #1;

        // lw: 0,1,2,3,4,0
        step("lw_fetch", 4'd0, V_FETCH);
        step("lw_decode", 4'd1, V_DECODE);
        step("lw_memadr", 4'd2, V_MEMADR);
        step("lw_memrd", 4'd3, V_MEMRD);
        step("lw_memwb", 4'd4, V_MEMWB);

        // R-type sub: 0,1,6,7,0
        bus.op = 6'b000000; bus.funct = 6'b100010;
        step("sub_fetch", 4'd0, V_FETCH);
        step("sub_decode", 4'd1, V_DECODE);
        step("sub_ex", 4'd6, v_rex(3'b110));
        step("sub_wb", 4'd7, V_RTYPEWB);

        bus.funct = 6'b100000;
        step("add_fetch", 4'd0, V_FETCH);
        step("add_decode", 4'd1, V_DECODE);
        step("add_ex", 4'd6, v_rex(3'b010));
        step("add_wb", 4'd7, V_RTYPEWB);

        bus.funct = 6'b100100;
        step("and_fetch", 4'd0, V_FETCH);
        step("and_decode", 4'd1, V_DECODE);
        step("and_ex", 4'd6, v_rex(3'b000));
        step("and_wb", 4'd7, V_RTYPEWB);

        bus.funct = 6'b100101;
        step("or_fetch", 4'd0, V_FETCH);
        step("or_decode", 4'd1, V_DECODE);
        step("or_ex", 4'd6, v_rex(3'b001));
        step("or_wb", 4'd7, V_RTYPEWB);

        bus.funct = 6'b101010;
        step("slt_fetch", 4'd0, V_FETCH);
        step("slt_decode", 4'd1, V_DECODE);
        step("slt_ex", 4'd6, v_rex(3'b111));
        step("slt_wb", 4'd7, V_RTYPEWB);

        // Unsupported funct: 0,1,6,0 with illegal in state 6
        bus.funct = 6'b000111;
        step("badf_fetch", 4'd0, V_FETCH);
        step("badf_decode", 4'd1, V_DECODE);
        step("badf_ex", 4'd6, V_R_ILL);

        // beq taken then not taken: 3 cycles each
        bus.op = 6'b000100; bus.zero = 1'b1;
        step("beqt_fetch", 4'd0, V_FETCH);
        step("beqt_decode", 4'd1, V_DECODE);
        step("beqt_ex", 4'd8, V_BEQ_T);
        bus.zero = 1'b0;
        step("beqn_fetch", 4'd0, V_FETCH);
        step("beqn_decode", 4'd1, V_DECODE);
        step("beqn_ex", 4'd8, V_BEQ_N);

        // sw: 0,1,2,5,0
        bus.op = 6'b101011;
        step("sw_fetch", 4'd0, V_FETCH);
        step("sw_decode", 4'd1, V_DECODE);
        step("sw_memadr", 4'd2, V_MEMADR);
        step("sw_memwr", 4'd5, V_MEMWR);

        // illegal op: 0,1,0
        bus.op = 6'b111111;
        step("ill_fetch", 4'd0, V_FETCH);
        step("ill_decode", 4'd1, V_DEC_ILL);

        // addi: 0,1,9,10,0
        bus.op = 6'b001000;
        step("addi_fetch", 4'd0, V_FETCH);
        step("addi_decode", 4'd1, V_DECODE);
        step("addi_ex", 4'd9, V_ADDIEX);
        step("addi_wb", 4'd10, V_ADDIWB);

        // j with zero=1 must not matter: 0,1,11,0
        bus.op = 6'b000010; bus.zero = 1'b1;
        step("j_fetch", 4'd0, V_FETCH);
        step("j_decode", 4'd1, V_DECODE);
        step("j_ex", 4'd11, V_JEX);
        bus.zero = 1'b0;

        // lw aborted by reset in MEMRD
        bus.op = 6'b100011;
        step("abort_fetch", 4'd0, V_FETCH);
        step("abort_decode", 4'd1, V_DECODE);
        step("abort_memadr", 4'd2, V_MEMADR);
        chk("abort_memrd", 4'd3, V_MEMRD);
        reset = 1'b1;
        #1;
        chk("abort_async", 4'd0, V_ZERO);
        @(posedge clk);
        @(negedge clk);
        chk("abort_held", 4'd0, V_ZERO);
        bus.op = 6'b000010;
        reset = 1'b0;
        #1;
        step("restart_fetch", 4'd0, V_FETCH);
        step("restart_decode", 4'd1, V_DECODE);
        step("restart_jex", 4'd11, V_JEX);
        step("restart_next", 4'd0, V_FETCH);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Moore-style control FSM that sequences the multicycle MIPS datapath across FETCH/DECODE/EXECUTE/MEM/WRITEBACK steps.
- Drives the external memory strobes (memread, memwrite), the register-file write enable and every datapath mux/enable.
- Decodes op/funct from the instruction register and branch outcome from the ALU zero flag.
- Sits inside mips_processor between the datapath and the external memory port.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word opcode
- OP_SW, 6'b101011, store word opcode
- OP_BEQ, 6'b000100, branch-equal opcode
- OP_ADDI, 6'b001000, add-immediate opcode
- OP_J, 6'b000010, jump opcode

Ports:
- clk  in  1  single system clock, rising-edge
- reset  in  1  asynchronous, active-high reset
- op  in  6  instruction[31:26] from instruction register
- funct  in  6  instruction[5:0] from instruction register
- zero  in  1  ALU zero flag
- memread  out  1  external memory read strobe
- memwrite  out  1  external memory write strobe
- irwrite  out  1  instruction register load
- regwrite  out  1  register file write enable
- regdst  out  1  1 = wrAddr from rd, 0 = from rt
- memtoreg  out  1  1 = wrData from memory data register
- iord  out  1  1 = addr from ALUOut, 0 = from PC
- alusrca  out  1  1 = Ain register, 0 = PC
- alusrcb  out  2  00 Bin, 01 PC increment constant, 10 sign-ext imm, 11 shifted imm
- pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target
- pcen  out  1  PC write enable
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- illegal  out  1  one-cycle pulse: unsupported op or funct decoded
- state  out  4  current state encoding, for debug and bench

Behaviour:
- States, with encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11
  - Encodings 12-15 are unused; if entered, next state is FETCH.
- State register: async reset to FETCH. While reset=1, all outputs are forced to 0 and state reads 0.
- Reset mid-instruction: the instruction is abandoned immediately. The first rising edge after deassertion evaluates FETCH.
- Outputs are a pure decode of the current state, except:
  - pcen = pcwrite | (branch & zero)
  - illegal
- Transitions:
  - FETCH -> DECODE
  - DECODE -> MEMADR (lw, sw), RTYPEEX, BEQEX, ADDIEX or JEX by op
  - DECODE -> FETCH with illegal=1 for any other op
  - MEMADR -> MEMRD if op=lw, else MEMWR
  - MEMRD -> MEMWB; MEMWB -> FETCH; MEMWR -> FETCH
  - RTYPEEX -> RTYPEWB; RTYPEWB -> FETCH
  - BEQEX -> FETCH; ADDIEX -> ADDIWB; ADDIWB -> FETCH; JEX -> FETCH
- Per-state asserted outputs; all other outputs are 0 and alucontrol=010:
  - FETCH: memread, irwrite, alusrcb=01, pcen (pcsrc=00, iord=0)
  - DECODE: alusrcb=11 (branch target precompute)
  - MEMADR: alusrca, alusrcb=10
  - MEMRD: memread, iord
  - MEMWB: regwrite, memtoreg (regdst=0)
  - MEMWR: memwrite, iord
  - RTYPEEX: alusrca, alusrcb=00, alucontrol from funct
  - RTYPEWB: regwrite, regdst
  - BEQEX: alusrca, alusrcb=00, alucontrol=110, branch, pcsrc=01
  - ADDIEX: alusrca, alusrcb=10
  - ADDIWB: regwrite (regdst=0, memtoreg=0)
  - JEX: pcen, pcsrc=10
- Funct decode in RTYPEEX:
  - 100000 -> 010; 100010 -> 110; 100100 -> 000; 100101 -> 001; 101010 -> 111
  - Any other funct: alucontrol=010, illegal=1 this cycle, and RTYPEWB is skipped (next state FETCH, no regwrite).
- Cycle counts, from FETCH to the next FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal op 2.
- memread and memwrite are never both 1 in the same cycle.

Test Plan:
- reset=1 for 2 cycles, then release -> all outputs 0 during reset. First cycle after release: state=0, memread=1, irwrite=1, pcen=1, alusrcb=01.
- op=100011 (lw) -> state sequence 0,1,2,3,4,0. memread=1 in states 0 and 3; iord=1 in state 3; regwrite=1 and memtoreg=1 only in state 4.
- op=000000, funct=100010 -> states 0,1,6,7,0. alucontrol=110 in state 6; regwrite=1 and regdst=1 in state 7.
- op=000100 with zero=1, then repeated with zero=0 -> in state 8, pcen=1 with pcsrc=01 for zero=1 and pcen=0 for zero=0; 3 cycles per instruction.
- op=101011 (sw), then op=111111 -> sw: states 0,1,2,5,0 with memwrite=1 only in state 5. Illegal op: states 0,1,0 with illegal=1 in state 1 and no regwrite or memwrite.
- lw in progress, reset pulsed while state=3 -> state goes to 0 asynchronously and memread drops to 0 immediately. After release, the FSM restarts at FETCH and regwrite is never asserted for the aborted load.
